// File: rtl/memory_mmio_if.sv
// CPU M-bus: word address, write data, write enable and combinational read data.
interface memory_mmio_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       address;
    logic [DATA_W-1:0] in;
    logic              load;
    logic [DATA_W-1:0] out;

    modport master (output address, in, load, input out);
    modport slave  (input address, in, load, output out);
endinterface

// File: rtl/memory_mmio.sv
// Hack data memory: parametrised RAM plus an I/O page holding an LED register,
// debounced button levels and sticky press flags.
module memory_mmio_btn #(
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int DEBOUNCE_CYC   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    input  logic clr_i,
    output logic stable_o,
    output logic press_o
);
    localparam int            CW      = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
    // Sync flops reset to the released pin level so reset reads as not-pressed.
    localparam logic          IDLE    = BTN_ACTIVE_LOW;

    logic          sync1_q, sync2_q, stable_q, press_q;
    logic          stable_d, press_d, synced, accept;
    logic [CW-1:0] cnt_q, cnt_d;

    assign synced = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign accept = (synced != stable_q) && (cnt_q == CNT_MAX);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (accept) begin
            stable_d = synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // A new press outranks a same-cycle clear.
        press_d = (accept && synced) | (press_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= IDLE;
            sync2_q  <= IDLE;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;
endmodule

module memory_mmio #(
    parameter int          DATA_W         = 16,
    parameter int          RAM_AW         = 13,
    parameter logic [15:0] IO_BASE        = 16'h2000,
    parameter int          NUM_LED        = 4,
    parameter int          NUM_BTN        = 4,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter int          DEBOUNCE_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_mmio_if.slave       bus,
    output logic [NUM_LED-1:0] led,
    input  logic [NUM_BTN-1:0] btn
);
    localparam int          RAM_WORDS = 2 ** RAM_AW;
    localparam logic [15:0] A_LED     = IO_BASE;
    localparam logic [15:0] A_BTN     = IO_BASE + 16'd1;
    localparam logic [15:0] A_PRS     = IO_BASE + 16'd2;

    logic [DATA_W-1:0]  ram [RAM_WORDS];
    logic [NUM_LED-1:0] led_q, led_d;
    logic [NUM_BTN-1:0] stable, press, prs_clr;
    logic [DATA_W-1:0]  rdata;
    logic               ram_hit;

    assign ram_hit = (32'(bus.address) < 32'(RAM_WORDS));
    assign prs_clr = (bus.load && bus.address == A_PRS) ? bus.in[NUM_BTN-1:0] : '0;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        memory_mmio_btn #(
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
            .DEBOUNCE_CYC   (DEBOUNCE_CYC)
        ) u_btn (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin_i    (btn[g]),
            .clr_i    (prs_clr[g]),
            .stable_o (stable[g]),
            .press_o  (press[g])
        );
    end

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (bus.load && ram_hit) ram[bus.address[RAM_AW-1:0]] <= bus.in;
    end

    always_comb begin
        led_d = led_q;
        if (bus.load && bus.address == A_LED) led_d = bus.in[NUM_LED-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= led_d;
    end

    always_comb begin
        rdata = '0;
        if (ram_hit)                    rdata = ram[bus.address[RAM_AW-1:0]];
        else if (bus.address == A_LED)  rdata[NUM_LED-1:0] = led_q;
        else if (bus.address == A_BTN)  rdata[NUM_BTN-1:0] = stable;
        else if (bus.address == A_PRS)  rdata[NUM_BTN-1:0] = press;
    end

    assign bus.out = rdata;
    assign led     = led_q;
endmodule
